// File: rtl/pred_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pred_fork_ctrl
// Brief    : Joins a data beat with a predicate mask and multicasts the beat
//            to every selected branch, tracking per-branch acknowledgements.
// Revision : 1.0 - initial release
// ============================================================================
module pred_fork_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int PORT_COUNT = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT-1:0]            s_pred_in_tdata,
    input  logic                             s_pred_in_tvalid,
    output logic                             s_pred_in_tready,
    input  logic [DATA_WIDTH-1:0]            s_data_tdata,
    input  logic                             s_data_tvalid,
    output logic                             s_data_tready,
    output logic [PORT_COUNT*DATA_WIDTH-1:0] m_branch_tdata,
    output logic [PORT_COUNT-1:0]            m_branch_tvalid,
    input  logic [PORT_COUNT-1:0]            m_branch_tready,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             stat_dispatch_cnt,
    output logic [CNT_WIDTH-1:0]             stat_drop_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [PORT_COUNT-1:0] r_pending;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_dispatch_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic                  w_idle;
    logic                  w_accept;
    logic [PORT_COUNT-1:0] w_remain;

    // Each input's ready follows the other's valid so neither is consumed alone.
    assign w_idle           = rst && (r_state == ST_IDLE);
    assign s_pred_in_tready = w_idle && s_data_tvalid;
    assign s_data_tready    = w_idle && s_pred_in_tvalid;
    assign w_accept         = w_idle && s_pred_in_tvalid && s_data_tvalid;
    assign w_remain         = r_pending & ~(r_pending & m_branch_tready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_data         <= '0;
            r_pending      <= '0;
            r_busy         <= 1'b0;
            r_dispatch_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (|s_pred_in_tdata) begin
                            r_data    <= s_data_tdata;
                            r_pending <= s_pred_in_tdata;
                            r_busy    <= 1'b1;
                            r_state   <= ST_DISPATCH;
                        end else if (r_drop_cnt != C_CNT_MAX) begin
                            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DISPATCH: begin
                    r_pending <= w_remain;
                    if (w_remain == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_dispatch_cnt != C_CNT_MAX) begin
                            r_dispatch_cnt <= r_dispatch_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_branch
            assign m_branch_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_data;
        end
    endgenerate

    assign m_branch_tvalid   = r_pending;
    assign busy              = r_busy;
    assign stat_dispatch_cnt = r_dispatch_cnt;
    assign stat_drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pred_fork_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pred_fork_ctrl
// Brief    : Directed and random stimulus for pred_fork_ctrl against a
//            beat-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pred_fork_ctrl;

    localparam int DW = 64;
    localparam int PC = 2;
    localparam int CW = 6;
    localparam longint C_SAT = (64'd1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PC-1:0] pred_data = '0;
    logic          pred_valid = 1'b0;
    logic          pred_ready;
    logic [DW-1:0] data_data = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [PC*DW-1:0] br_data;
    logic [PC-1:0] br_valid;
    logic [PC-1:0] br_ready = '0;
    logic          busy;
    logic [CW-1:0] disp_cnt;
    logic [CW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: one held beat plus the set of branches still owed it.
    logic          m_have;
    logic [PC-1:0] m_owed;
    logic [DW-1:0] m_beat;
    longint        m_disp;
    longint        m_drop;

    pred_fork_ctrl #(.DATA_WIDTH(DW), .PORT_COUNT(PC), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_pred_in_tdata   (pred_data),
        .s_pred_in_tvalid  (pred_valid),
        .s_pred_in_tready  (pred_ready),
        .s_data_tdata      (data_data),
        .s_data_tvalid     (data_valid),
        .s_data_tready     (data_ready),
        .m_branch_tdata    (br_data),
        .m_branch_tvalid   (br_valid),
        .m_branch_tready   (br_ready),
        .busy              (busy),
        .stat_dispatch_cnt (disp_cnt),
        .stat_drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        m_owed = '0;
        m_beat = '0;
        m_disp = 0;
        m_drop = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, check, then advance the model.
    task automatic step(input logic r, input logic pv, input logic [PC-1:0] pm,
                        input logic dv, input logic [DW-1:0] d, input logic [PC-1:0] br);
        rst        = r;
        pred_valid = pv;
        pred_data  = pm;
        data_valid = dv;
        data_data  = d;
        br_ready   = br;
        if (!r) model_reset();
        #1;
        chk("pred_ready", 128'(pred_ready), 128'(r && !m_have && dv));
        chk("data_ready", 128'(data_ready), 128'(r && !m_have && pv));
        chk("br_valid",   128'(br_valid),   128'(m_have ? m_owed : '0));
        chk("br_data",    br_data,          {m_beat, m_beat});
        chk("busy",       128'(busy),       128'(m_have));
        chk("disp_cnt",   128'(disp_cnt),   128'(m_disp));
        chk("drop_cnt",   128'(drop_cnt),   128'(m_drop));
        if (r) begin
            if (!m_have) begin
                if (pv && dv) begin
                    if (pm == '0) begin
                        if (m_drop < C_SAT) m_drop++;
                    end else begin
                        m_have = 1'b1;
                        m_owed = pm;
                        m_beat = d;
                    end
                end
            end else begin
                m_owed = m_owed & ~br;
                if (m_owed == '0) begin
                    m_have = 1'b0;
                    if (m_disp < C_SAT) m_disp++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input logic [PC-1:0] br);
        step(1'b1, 1'b0, '0, 1'b0, '0, br);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset held with random inputs: nothing visible.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom}, 2'($urandom));
        idle_step('0);
        idle_step('0);

        // Broadcast with all readies high.
        step(1'b1, 1'b1, 2'b11, 1'b1, 64'hA5, 2'b11);
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, 2'b11);
        chk("bcast_done", 128'(disp_cnt), 128'd1);
        idle_step(2'b11);

        // Partial ack: branch 0 at cycle 1, branch 1 at cycle 4, inputs stalled.
        step(1'b1, 1'b1, 2'b11, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b00);
        step(1'b1, 1'b1, 2'b01, 1'b1, 64'h55, 2'b01);
        step(1'b1, 1'b1, 2'b01, 1'b1, 64'h55, 2'b00);
        step(1'b1, 1'b1, 2'b01, 1'b1, 64'h55, 2'b01);
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, 2'b10);
        chk("partial_done", 128'(disp_cnt), 128'd2);
        idle_step('0);

        // Three back-to-back zero-mask beats.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b00, 1'b1, 64'(i + 7), 2'b11);
        idle_step('0);
        chk("drop3", 128'(drop_cnt), 128'd3);

        // Join: data alone is never consumed.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 2'b01, 1'b1, 64'hBEEF, 2'b00);
        step(1'b1, 1'b1, 2'b01, 1'b1, 64'hBEEF, 2'b00);
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, 2'b00);

        // Reset during dispatch drops the held beat without counting it.
        idle_step(2'b00);
        step(1'b1, 1'b1, 2'b10, 1'b1, 64'hCAFE, 2'b00);
        step(1'b1, 1'b0, 2'b00, 1'b0, '0, 2'b00);
        step(1'b0, 1'b0, 2'b00, 1'b0, '0, 2'b00);
        chk("rst_valid", 128'(br_valid), 128'd0);
        chk("rst_disp",  128'(disp_cnt), 128'd0);
        idle_step('0);

        // Drop counter saturation.
        for (int i = 0; i < 70; i++)
            step(1'b1, 1'b1, 2'b00, 1'b1, 64'(i), 2'b00);
        idle_step('0);
        chk("drop_sat", 128'(drop_cnt), 128'(C_SAT));

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0), 2'($urandom),
                 ($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pred_fork_ctrl.md
Name: pred_fork_ctrl

Overview:
- Predicated fork controller. It sits downstream of the predicate demux stage and sequences one data stream onto PORT_COUNT branch outputs.
- Each accepted data beat is joined with one predicate bitmask beat and multicast to every branch whose mask bit is 1.
- Branches complete independently; partial acknowledgements are tracked.
- A beat with an all-zero mask is dropped and counted.

Parameters:
- DATA_WIDTH, 64, width of the data beat.
- PORT_COUNT, 2, number of branch outputs; equals the width of the predicate mask.
- CNT_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- s_pred_in_tdata  input  PORT_COUNT  predicate mask; bit i selects branch i.
- s_pred_in_tvalid  input  1  predicate mask valid.
- s_pred_in_tready  output  1  predicate mask accepted.
- s_data_tdata  input  DATA_WIDTH  data beat.
- s_data_tvalid  input  1  data beat valid.
- s_data_tready  output  1  data beat accepted.
- m_branch_tdata  output  PORT_COUNT*DATA_WIDTH  held beat replicated into every DATA_WIDTH slice.
- m_branch_tvalid  output  PORT_COUNT  per-branch valid.
- m_branch_tready  input  PORT_COUNT  per-branch ready.
- busy  output  1  high while in DISPATCH.
- stat_dispatch_cnt  output  CNT_WIDTH  beats fully delivered to all selected branches.
- stat_drop_cnt  output  CNT_WIDTH  beats dropped because the mask was zero.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Holding data register and pending mask cleared to 0.
  - m_branch_tvalid=0, m_branch_tdata=0, busy=0, both counters=0.
  - Ready outputs are 0 while rst=0.
  - Reset during DISPATCH discards the held beat; no counter increments for it.
  - Release is synchronous to clk: the first IDLE cycle is the first edge with rst=1.
- States: IDLE, DISPATCH.
- IDLE, join rule:
  - s_pred_in_tready = s_data_tvalid.
  - s_data_tready = s_pred_in_tvalid.
  - Readies are combinational from the opposite valid; neither input is consumed alone.
  - Accept edge: both valids are high while in IDLE.
- On accept with mask != 0:
  - Latch data into the holding register and mask into pending.
  - Go to DISPATCH.
  - Branch valids assert the next cycle: latency 1 from accept.
- On accept with mask == 0:
  - Beat is consumed and discarded.
  - stat_drop_cnt increments.
  - Stay in IDLE; a new beat can be accepted next cycle.
- DISPATCH:
  - Both s_*_tready = 0.
  - m_branch_tvalid = pending.
  - m_branch_tdata is stable for the whole DISPATCH.
  - busy=1.
  - Each edge: pending <= pending & ~(m_branch_tvalid & m_branch_tready).
  - A branch is never re-presented after its handshake.
  - Ready on a branch whose valid is low has no effect.
- Completion:
  - When (pending & ~(m_branch_tvalid & m_branch_tready)) == 0 on an edge: stat_dispatch_cnt increments and state returns to IDLE.
  - All selected branches ready together completes DISPATCH in a single cycle.
- Throughput: at most one non-zero-mask beat every 2 cycles (accept, dispatch). Zero-mask beats can be dropped every cycle.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - An increment is ignored once saturated.
  - The two counters never increment in the same cycle.
- m_branch_tvalid bits never deassert before their handshake completes (AXI-stream stability). Data does not change during DISPATCH.
- Inputs presented while in DISPATCH stay stalled (tready=0) until return to IDLE.

Test Plan:
- Reset/idle: hold rst=0 with random inputs -> every ready, valid and counter is 0. Release with no valids -> state IDLE, busy=0.
- Broadcast, PORT_COUNT=2: data 0xA5, mask 2'b11, all readies high -> both valids high one cycle after accept for exactly 1 cycle, both slices 0xA5. dispatch_cnt=1, back in IDLE next cycle.
- Partial ack: mask 2'b11; ready[0]=1 at cycle 1, ready[1]=0 until cycle 4 ->
  - valid[0] drops after cycle 1; valid[1] stays high through cycle 4.
  - Inputs stalled throughout.
  - dispatch_cnt increments at cycle 4.
- Zero mask: three back-to-back beats with mask 0 -> all consumed in 3 cycles, drop_cnt=3, no branch valid ever asserted.
- Join: data valid high with pred valid low for 5 cycles -> s_data_tready stays 0 and nothing is consumed. Pred valid then rises -> both accepted on the same edge.
- Reset mid-DISPATCH: mask 2'b10 with ready[1]=0, pull rst low -> valid[1] clears immediately (asynchronous), dispatch_cnt unchanged. Counter saturation check: preload-by-force drop_cnt to all-ones, one further drop -> value stays all-ones.
